// File: rtl/heater_pkg.sv
// Shared heater-control constants and state encoding, reused by the PID and sensor blocks.
package heater_pkg;

  localparam int unsigned HEATER_WIDTH     = 25;
  localparam int unsigned HEATER_PERIOD    = 28_800_900;
  localparam int unsigned HEATER_MIN_PULSE = 27_000;
  localparam int unsigned HEATER_MAX_ON    = 28_800_901;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } heater_state_e;

endpackage

// File: rtl/heater_window_counter.sv
// Control-window counter: counts 0..PERIOD and wraps; registered window-start pulse.
module heater_window_counter
  import heater_pkg::*;
#(
  parameter int unsigned WIDTH  = HEATER_WIDTH,
  parameter int unsigned PERIOD = HEATER_PERIOD
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_i,
  input  logic             run_next_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             window_start_o
);

  localparam logic [WIDTH-1:0] LastCnt = WIDTH'(PERIOD);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ws_q, ws_d;

  always_comb begin
    if (clr_i || (cnt_q == LastCnt)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Pulse is registered so it lines up with the cycle where cnt_q reads 0.
    ws_d = run_next_i && (cnt_d == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      ws_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ws_q  <= ws_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign wrap_o         = (cnt_q == LastCnt);
  assign window_start_o = ws_q;

endmodule

// File: rtl/heater_window_ctrl.sv
// Time-proportioning heater sequencer: per-window duty handshake, double-buffered duty,
// min-pulse / max-duty limiting and over-temperature lockout.
module heater_window_ctrl
  import heater_pkg::*;
#(
  parameter int unsigned WIDTH     = HEATER_WIDTH,
  parameter int unsigned PERIOD    = HEATER_PERIOD,
  parameter int unsigned MIN_PULSE = HEATER_MIN_PULSE,
  parameter int unsigned MAX_ON    = HEATER_MAX_ON
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             duty_valid_i,
  output logic             duty_ready_o,
  input  logic             overtemp_i,
  input  logic             fault_clr_i,
  output logic             sample_req_o,
  output logic             window_start_o,
  output logic             heat_on_o,
  output logic             stale_o,
  output logic             fault_o
);

  localparam logic [WIDTH-1:0] MinPulse = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] MaxOn    = WIDTH'(MAX_ON);

  heater_state_e    state_q, state_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ready_q, ready_d;
  logic             heat_q, heat_d;
  logic             stale_q, stale_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             window_start;
  logic             cnt_clr;
  logic             run_next;
  logic             xfer;
  logic [WIDTH-1:0] lim_duty;

  // Counter only advances while RUN continues; any other transition restarts it at 0.
  assign run_next = (state_d == StRun);
  assign cnt_clr  = !((state_q == StRun) && run_next);

  heater_window_counter #(
    .WIDTH  (WIDTH),
    .PERIOD (PERIOD)
  ) u_counter (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .clr_i          (cnt_clr),
    .run_next_i     (run_next),
    .cnt_o          (cnt),
    .wrap_o         (wrap),
    .window_start_o (window_start)
  );

  always_comb begin
    lim_duty = duty_i;
    if (duty_i < MinPulse) begin
      lim_duty = '0;
    end else if (duty_i > MaxOn) begin
      lim_duty = MaxOn;
    end
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    ready_d    = ready_q;
    heat_d     = 1'b0;
    stale_d    = 1'b0;
    fault_d    = 1'b0;
    xfer       = duty_valid_i && ready_q;

    if (overtemp_i) begin
      state_d    = StFault;
      active_d   = '0;
      pend_vld_d = 1'b0;
      ready_d    = 1'b0;
      fault_d    = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_d    = 1'b0;
          pend_vld_d = 1'b0;
          if (en_i) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!en_i) begin
            state_d    = StIdle;
            pend_vld_d = 1'b0;
            ready_d    = 1'b0;
          end else begin
            heat_d = (cnt < active_q);
            if (xfer) begin
              pending_d  = lim_duty;
              pend_vld_d = 1'b1;
            end
            // A transfer on the wrap cycle belongs to the closing window.
            if (wrap) begin
              if (xfer) begin
                active_d   = lim_duty;
                pend_vld_d = 1'b0;
              end else if (pend_vld_q) begin
                active_d   = pending_q;
                pend_vld_d = 1'b0;
              end else begin
                stale_d = 1'b1;
              end
            end
            if (window_start) begin
              ready_d = 1'b1;
            end else if (xfer || wrap) begin
              ready_d = 1'b0;
            end
          end
        end
        StFault: begin
          fault_d = 1'b1;
          if (fault_clr_i) begin
            state_d = StIdle;
            fault_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      active_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b0;
      heat_q     <= 1'b0;
      stale_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      heat_q     <= heat_d;
      stale_q    <= stale_d;
      fault_q    <= fault_d;
    end
  end

  assign duty_ready_o   = ready_q;
  assign sample_req_o   = window_start;
  assign window_start_o = window_start;
  assign heat_on_o      = heat_q;
  assign stale_o        = stale_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_heater_window_ctrl.sv
// Self-checking bench for heater_window_ctrl with a short window (PERIOD=9).
module tb_heater_window_ctrl;

  localparam int unsigned W = 25;

  logic         CLK;
  logic         RST_N;
  logic         en;
  logic [W-1:0] duty;
  logic         duty_valid;
  logic         duty_ready;
  logic         overtemp;
  logic         fault_clr;
  logic         sample_req;
  logic         window_start;
  logic         heat_on;
  logic         stale;
  logic         fault;

  int checks = 0;
  int errors = 0;
  int sb[$];

  heater_window_ctrl #(
    .WIDTH     (W),
    .PERIOD    (9),
    .MIN_PULSE (2),
    .MAX_ON    (8)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .en_i           (en),
    .duty_i         (duty),
    .duty_valid_i   (duty_valid),
    .duty_ready_o   (duty_ready),
    .overtemp_i     (overtemp),
    .fault_clr_i    (fault_clr),
    .sample_req_o   (sample_req),
    .window_start_o (window_start),
    .heat_on_o      (heat_on),
    .stale_o        (stale),
    .fault_o        (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_heat"}, heat_on, 0);
    check_eq({tag, "_ready"}, duty_ready, 0);
    check_eq({tag, "_sreq"}, sample_req, 0);
    check_eq({tag, "_ws"}, window_start, 0);
    check_eq({tag, "_stale"}, stale, 0);
    check_eq({tag, "_fault"}, fault, 0);
  endtask

  // Entered at the cnt=0 cycle of a window; leaves at cnt=0 of the next one.
  // Heater on-time of a window spans cnt=1..PERIOD plus the next window's cnt=0.
  task automatic do_window(input bit give, input int d, input bit at_wrap, input bit hold,
                           input int exp_next);
    int on_cnt;
    on_cnt = 0;
    sb.push_back(exp_next);
    for (int k = 1; k <= 9; k++) begin
      tick();
      on_cnt += int'(heat_on);
      if (k == 1) check_eq("ready_rise", duty_ready, 1);
      if (give && !at_wrap) begin
        if (k == 1) begin
          duty_valid = 1'b1;
          duty = W'(d);
        end
        if (k == 2) begin
          check_eq("ready_drop", duty_ready, 0);
          if (hold) duty = W'(d ^ 3);
          else duty_valid = 1'b0;
        end
        if (k == 8) duty_valid = 1'b0;
      end
      if (k == 9) begin
        if (give && at_wrap) begin
          check_eq("ready_at_wrap", duty_ready, 1);
          duty_valid = 1'b1;
          duty = W'(d);
        end
        if (!give) check_eq("ready_open", duty_ready, 1);
      end
    end
    tick();
    on_cnt += int'(heat_on);
    duty_valid = 1'b0;
    check_eq("window_start", window_start, 1);
    check_eq("sample_req", sample_req, 1);
    check_eq("stale", stale, !give);
    check_eq("ready_boundary", duty_ready, 0);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      check_eq("on_count", on_cnt, sb.pop_front());
    end
  endtask

  initial begin
    RST_N = 1'b0;
    en = 1'b0;
    duty = '0;
    duty_valid = 1'b0;
    overtemp = 1'b0;
    fault_clr = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    RST_N = 1'b1;
    tick();
    check_all_zero("idle");

    en = 1'b1;
    tick();
    check_eq("first_ws", window_start, 1);
    check_eq("first_ready", duty_ready, 0);
    sb.push_back(0);
    do_window(1, 5, 0, 0, 5);    // window 0: off
    do_window(1, 1, 0, 0, 0);    // 5 on
    do_window(1, 12, 0, 0, 8);   // below min pulse -> 0
    do_window(1, 5, 0, 1, 5);    // clamped -> 8; valid held after transfer
    do_window(0, 0, 0, 0, 5);    // 5 on, no duty -> stale
    do_window(1, 7, 1, 0, 7);    // 5 repeats; transfer on the wrap cycle
    do_window(1, 5, 0, 0, 5);    // 7 on

    // Over-temperature mid-pulse.
    repeat (3) tick();
    check_eq("ot_pre_heat", heat_on, 1);
    overtemp = 1'b1;
    tick();
    overtemp = 1'b0;
    check_eq("ot_heat", heat_on, 0);
    check_eq("ot_fault", fault, 1);
    check_eq("ot_ready", duty_ready, 0);
    tick();
    check_eq("fault_sticky", fault, 1);
    overtemp = 1'b1;
    fault_clr = 1'b1;
    tick();
    check_eq("clr_ignored", fault, 1);
    overtemp = 1'b0;
    tick();
    fault_clr = 1'b0;
    check_eq("clr_fault", fault, 0);
    check_eq("clr_heat", heat_on, 0);
    check_eq("clr_ws", window_start, 0);
    tick();
    check_eq("reenter_ws", window_start, 1);
    sb.delete();
    sb.push_back(0);
    do_window(1, 5, 0, 0, 5);    // active cleared by the fault

    // EN dropped at cnt=3 with a pending duty that must be discarded.
    tick();
    duty_valid = 1'b1;
    duty = W'(3);
    tick();
    duty_valid = 1'b0;
    tick();
    check_eq("en_pre_heat", heat_on, 1);
    en = 1'b0;
    tick();
    check_eq("en_off_heat", heat_on, 0);
    check_eq("en_off_ready", duty_ready, 0);
    check_eq("en_off_ws", window_start, 0);
    tick();
    check_eq("idle_heat", heat_on, 0);
    en = 1'b1;
    tick();
    check_eq("restart_ws", window_start, 1);
    sb.delete();
    sb.push_back(5);
    do_window(0, 0, 0, 0, 5);    // active retained, pending gone

    // Asynchronous reset mid-window.
    repeat (3) tick();
    check_eq("rst_pre_heat", heat_on, 1);
    RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    RST_N = 1'b1;
    tick();
    check_eq("post_rst_ws", window_start, 1);
    sb.delete();
    sb.push_back(0);
    do_window(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heater_window_ctrl.md
Name: heater_window_ctrl

Overview:
- Sequences the heater's time-proportioning output.
- Runs a fixed-length control window and requests a new duty value from the PID/compute stage once per window, using a valid/ready handshake.
- Double-buffers the accepted duty so it takes effect only at the next window boundary, then drives the heater enable for exactly that many clocks.
- Enforces minimum-pulse and maximum-duty limits, plus an over-temperature fault lockout. Sits between the PID compute block and the heater SSR driver pin.

Parameters:
- WIDTH, 25, width of duty and window counter.
- PERIOD, 28_800_900, last counter value; window length = PERIOD+1 clocks (≈1.0667 s at 27 MHz).
- MIN_PULSE, 27_000, duties below this value are forced to 0 (SSR protection).
- MAX_ON, 28_800_901, duty clamp; MAX_ON ≤ PERIOD+1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  control enable; level.
- DUTY  in  WIDTH  requested on-time in clocks.
- DUTY_VALID  in  1  DUTY valid.
- DUTY_READY  out  1  controller accepts DUTY.
- OVERTEMP  in  1  synchronous over-temperature flag.
- FAULT_CLR  in  1  fault clear request.
- SAMPLE_REQ  out  1  one-cycle pulse at window start; triggers sensor read/PID update.
- WINDOW_START  out  1  one-cycle pulse when counter is 0.
- HEAT_ON  out  1  registered heater enable.
- STALE  out  1  one-cycle pulse at a boundary where no new duty arrived.
- FAULT  out  1  lockout active.

Behaviour:
- Reset (RST_N=0):
  - State IDLE; cnt=0; active=0; pending_valid=0.
  - All outputs 0.
- States: IDLE, RUN, FAULT. All outputs are registered.
- IDLE:
  - cnt held at 0; HEAT_ON=0; DUTY_READY=0.
  - EN=1 → RUN, with cnt=0 in the first RUN cycle.
- RUN, counter:
  - cnt increments each clock and wraps PERIOD→0.
  - While cnt==0: WINDOW_START=1 and SAMPLE_REQ=1.
- RUN, handshake:
  - DUTY_READY is set the cycle after WINDOW_START.
  - It stays high until DUTY_VALID&DUTY_READY; only one transfer per window. DUTY_READY drops the cycle after the transfer.
  - Transfer stores lim(DUTY) in pending and sets pending_valid.
  - DUTY_VALID asserted without DUTY_READY is ignored; the source must hold it.
- Limit function: lim(d) = 0 if d < MIN_PULSE; MAX_ON if d > MAX_ON; else d.
- Boundary, on the cycle cnt wraps PERIOD→0:
  - If pending_valid: active<=pending and pending_valid<=0.
  - Otherwise active is kept and STALE pulses.
  - If a transfer occurs in that same cycle, it belongs to the closing window and is applied (not stale).
  - DUTY_READY is cleared at the boundary if no transfer occurred.
- HEAT_ON:
  - HEAT_ON <= (state==RUN) && (cnt < active) && !OVERTEMP.
  - This lags cnt by one cycle, so HEAT_ON is high for exactly active consecutive clocks per window, starting the cycle after WINDOW_START.
  - active=PERIOD+1 gives continuous on across windows.
- First window after entering RUN uses active as held. active resets to 0 only on RST_N or on a FAULT entry.
- EN=0 in RUN:
  - → IDLE next cycle; HEAT_ON=0; pending discarded; active retained.
  - EN=1 again restarts the window at cnt=0.
- OVERTEMP=1 in any state, EN irrelevant:
  - → FAULT next cycle; HEAT_ON=0 on that same edge; FAULT=1.
  - active=0; pending_valid=0; DUTY_READY=0.
- FAULT:
  - Sticky.
  - Exits to IDLE only when FAULT_CLR=1 && OVERTEMP=0; FAULT=0 next cycle.
  - FAULT_CLR while OVERTEMP=1 is ignored.
- Priority: RST_N > OVERTEMP > EN=0 > boundary/handshake.
- Width: cnt compare is unsigned WIDTH-bit; PERIOD must fit WIDTH.

Decomposition:
- Shared package heater_pkg:
  - state encoding (IDLE/RUN/FAULT);
  - WIDTH, default PERIOD, MIN_PULSE, MAX_ON constants reused by the PID and sensor blocks.
- One natural sub-module: heater_window_counter (cnt, wrap, WINDOW_START generation, synchronous clear).
- The limit function stays inline.

Test Plan (PERIOD=9, MIN_PULSE=2, MAX_ON=8):
- Reset, EN=1, DUTY=5 accepted in window 0 → window 0 HEAT_ON=0 for all 10 clocks; window 1 HEAT_ON high exactly 5 clocks, starting the cycle after WINDOW_START; SAMPLE_REQ pulses every 10 clocks.
- DUTY=1 then DUTY=12 in successive windows → applied duties 0 then 8; HEAT_ON high 0 and 8 clocks.
- No DUTY_VALID in a window → STALE pulse at wrap; previous duty (5) repeats; DUTY_VALID held with ready low is not consumed twice.
- Transfer coincident with the wrap cycle → value applied at that boundary; no STALE.
- OVERTEMP for 1 cycle mid-pulse → HEAT_ON low next edge, FAULT=1; FAULT_CLR with OVERTEMP=1 ignored; FAULT_CLR with OVERTEMP=0 → IDLE; re-enable gives window with active=0.
- EN dropped at cnt=3, RST_N asserted mid-window → HEAT_ON=0 next cycle / immediately; all outputs 0; re-enable restarts at cnt=0.
